// File: rtl/camac_seq_pkg.sv
// Shared state encoding and default phase timing for the CAMAC cycle sequencer.
package camac_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_XWAIT,
        ST_S1,
        ST_GAP,
        ST_S2,
        ST_HOLD,
        ST_RELEASE
    } state_t;

    localparam int DEF_ADDR_W  = 2;
    localparam int DEF_T_SETUP = 2;
    localparam int DEF_T_S1    = 3;
    localparam int DEF_T_GAP   = 1;
    localparam int DEF_T_S2    = 3;
    localparam int DEF_T_HOLD  = 1;
    localparam int DEF_TIMEOUT = 16;

    function automatic int max2(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

endpackage

// File: rtl/camac_phase_timer.sv
// Phase down-counter: loaded on every state entry, stops at zero (never wraps).
module camac_phase_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (count != '0)
            count <= count - 1'b1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/camac_cycle_sequencer.sv
// Turns one ISA access into one timed CAMAC dataway cycle, holding rdy low until it ends.
module camac_cycle_sequencer
    import camac_seq_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int T_SETUP = DEF_T_SETUP,
    parameter int T_S1    = DEF_T_S1,
    parameter int T_GAP   = DEF_T_GAP,
    parameter int T_S2    = DEF_T_S2,
    parameter int T_HOLD  = DEF_T_HOLD,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sel,
    input  logic [ADDR_W-1:0] a,
    input  logic              w,
    input  logic              ie,
    input  logic              cx1,
    input  logic              cq,
    output logic              rdy,
    output logic              c1,
    output logic              c2,
    output logic              sel2,
    output logic [ADDR_W-1:0] addr_l,
    output logic              wr_l,
    output logic              x0,
    output logic              x1,
    output logic              tmo,
    output logic              irq
);

    localparam int TMAX = max2(max2(max2(T_SETUP, T_S1), max2(T_GAP, T_S2)),
                               max2(T_HOLD, TIMEOUT));
    localparam int TW   = $clog2(TMAX + 1);

    state_t            state, next;
    logic              done, done_n;
    logic              x0_n, x1_n, tmo_n, wr_n;
    logic [ADDR_W-1:0] addr_n;
    logic              tmr_load, tmr_zero;
    logic [TW-1:0]     tmr_val;
    logic              busy_n;

    camac_phase_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // Each timed state is loaded with (duration-1) and exits when the timer reads zero.
    always_comb begin
        next     = state;
        tmr_load = 1'b0;
        tmr_val  = '0;
        done_n   = done;
        x0_n     = x0;
        x1_n     = x1;
        tmo_n    = tmo;
        addr_n   = addr_l;
        wr_n     = wr_l;
        unique case (state)
            ST_IDLE: if (sel) begin
                next     = ST_SETUP;
                tmr_load = 1'b1;
                tmr_val  = TW'(T_SETUP - 1);
                addr_n   = a;
                wr_n     = w;
                x0_n     = 1'b0;
                x1_n     = 1'b0;
                tmo_n    = 1'b0;
                done_n   = 1'b0;
            end
            ST_SETUP: begin
                if (!sel)
                    next = ST_IDLE;
                else if (tmr_zero) begin
                    next     = ST_XWAIT;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(TIMEOUT - 1);
                end
            end
            // Abort beats both X acceptance and timeout on the same edge.
            ST_XWAIT: begin
                if (!sel)
                    next = ST_IDLE;
                else if (cx1) begin
                    next     = ST_S1;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(T_S1 - 1);
                    x0_n     = 1'b1;
                end else if (tmr_zero) begin
                    next   = ST_RELEASE;
                    tmo_n  = 1'b1;
                    done_n = 1'b1;
                end
            end
            ST_S1: if (tmr_zero) begin
                next     = ST_GAP;
                tmr_load = 1'b1;
                tmr_val  = TW'(T_GAP - 1);
                x1_n     = cq;
            end
            ST_GAP: if (tmr_zero) begin
                next     = ST_S2;
                tmr_load = 1'b1;
                tmr_val  = TW'(T_S2 - 1);
            end
            ST_S2: if (tmr_zero) begin
                next     = ST_HOLD;
                tmr_load = 1'b1;
                tmr_val  = TW'(T_HOLD - 1);
            end
            ST_HOLD: if (tmr_zero) begin
                next   = ST_RELEASE;
                done_n = 1'b1;
            end
            ST_RELEASE: if (!sel) next = ST_IDLE;
            default: next = ST_IDLE;
        endcase
    end

    assign busy_n = (next != ST_IDLE) && (next != ST_RELEASE);

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            rdy    <= 1'b1;
            c1     <= 1'b0;
            c2     <= 1'b0;
            sel2   <= 1'b0;
            addr_l <= '0;
            wr_l   <= 1'b0;
            x0     <= 1'b0;
            x1     <= 1'b0;
            tmo    <= 1'b0;
            done   <= 1'b0;
            irq    <= 1'b0;
        end else begin
            state  <= next;
            rdy    <= !busy_n;
            sel2   <= busy_n;
            c1     <= (next == ST_S1);
            c2     <= (next == ST_S2);
            addr_l <= addr_n;
            wr_l   <= wr_n;
            x0     <= x0_n;
            x1     <= x1_n;
            tmo    <= tmo_n;
            done   <= done_n;
            irq    <= ie & done_n;
        end
    end

endmodule

// File: tb/tb_camac_cycle_sequencer.sv
// Directed + randomized bench; expectations come from per-transaction timing arithmetic.
module tb_camac_cycle_sequencer;

    localparam int AW = 2, TS = 2, TS1 = 3, TG = 1, TS2 = 3, TH = 1, TO = 16;

    logic          clk = 1'b0;
    logic          reset, sel, w, ie, cx1, cq;
    logic [AW-1:0] a;
    logic          rdy, c1, c2, sel2, wr_l, x0, x1, tmo, irq;
    logic [AW-1:0] addr_l;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    camac_cycle_sequencer #(
        .ADDR_W(AW), .T_SETUP(TS), .T_S1(TS1), .T_GAP(TG),
        .T_S2(TS2), .T_HOLD(TH), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset), .sel(sel), .a(a), .w(w), .ie(ie),
        .cx1(cx1), .cq(cq), .rdy(rdy), .c1(c1), .c2(c2), .sel2(sel2),
        .addr_l(addr_l), .wr_l(wr_l), .x0(x0), .x1(x1), .tmo(tmo), .irq(irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // j: edge index (0 = edge that samples sel=1) from which cx1 is held high.
    // cqv[n]: cq value presented to edge n.  drop_at: first edge seeing sel=0 (<1 = never).
    task automatic run_txn(input logic [AW-1:0] ta, input logic tw, input int j,
                           input logic [127:0] cqv, input int drop_at, input logic tie);
        int  acc, lowexp, n, low, n1, n2, ovl, s2m, hold_bad;
        bit  to, abort, fin;
        acc    = (j > TS + 1) ? j : TS + 1;
        to     = (acc > TS + TO);
        abort  = (drop_at >= 1) && (drop_at <= (to ? TS + TO : acc));
        lowexp = abort ? drop_at : (to ? TS + TO : acc + TS1 + TG + TS2 + TH);
        low = 0; n1 = 0; n2 = 0; ovl = 0; s2m = 0; hold_bad = 0; fin = 0;

        @(negedge clk);
        sel = 1'b1; a = ta; w = tw; ie = tie; cx1 = (j <= 0); cq = cqv[0];
        n = 1;
        while (!fin && n < 100) begin
            @(negedge clk);
            if (n == 1) chk("irq_clear_on_start", irq, 0);
            if (c1) n1++;
            if (c2) n2++;
            if (c1 && c2) ovl++;
            if (sel2 !== !rdy) s2m++;
            if (rdy) fin = 1;
            else begin
                low++;
                sel = !((drop_at >= 1) && (n >= drop_at));
                cx1 = (n >= j);
                cq  = cqv[n];
            end
            n++;
        end
        if (!fin) chk("rdy_return_bound", 0, 1);
        chk("rdy_low_len", low, lowexp);
        chk("c1_len", n1, (to || abort) ? 0 : TS1);
        chk("c2_len", n2, (to || abort) ? 0 : TS2);
        chk("strobe_overlap", ovl, 0);
        chk("sel2_vs_rdy", s2m, 0);
        chk("addr_l", addr_l, ta);
        chk("wr_l", wr_l, tw);
        chk("x0", x0, !to && !abort);
        chk("tmo", tmo, to && !abort);
        chk("x1", x1, (!to && !abort) ? cqv[acc + TS1] : 1'b0);
        chk("irq", irq, tie && !abort);

        if (drop_at < 1) begin
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                if (!rdy || c1 || c2 || sel2) hold_bad++;
            end
            chk("release_hold", hold_bad, 0);
        end
        sel = 1'b0; cx1 = 1'b0; cq = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("idle_rdy", rdy, 1);
        chk("idle_sel2", sel2, 0);
    endtask

    initial begin
        logic [127:0] cqv;
        int           bad, bound;
        reset = 1'b1; sel = 1'b0; a = '0; w = 1'b0; ie = 1'b0; cx1 = 1'b0; cq = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_rdy", rdy, 1);
        chk("rst_outs", {c1, c2, sel2, addr_l, wr_l, x0, x1, tmo, irq}, 0);
        reset = 1'b0;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (!rdy || c1 || c2 || sel2) bad++;
        end
        chk("idle_no_activity", bad, 0);

        // Nominal cycle, timeout, and the two X-acceptance boundaries.
        run_txn(2'd2, 1'b1, 0, {$urandom(), $urandom(), $urandom(), $urandom()}, -1, 1'b0);
        run_txn(2'd1, 1'b0, 1000, '0, -1, 1'b0);
        run_txn(2'd3, 1'b1, TS + TO, '0, -1, 1'b0);
        run_txn(2'd0, 1'b0, TS + TO + 1, '0, -1, 1'b1);

        // Q capture window: only last S1 clock counts, S2 does not.
        cqv = '0; cqv[TS + 1 + TS1] = 1'b1;
        run_txn(2'd1, 1'b1, 0, cqv, -1, 1'b0);
        cqv = '0; for (int k = 0; k < TS2; k++) cqv[TS + 1 + TS1 + TG + 1 + k] = 1'b1;
        run_txn(2'd1, 1'b1, 0, cqv, -1, 1'b0);

        // Abort during XWAIT; sel drop during S2 must not abort.
        run_txn(2'd2, 1'b0, 1000, '0, TS + 3, 1'b1);
        run_txn(2'd3, 1'b1, 0, '0, TS + 1 + TS1 + TG + 2, 1'b1);

        // Full cycle with irq, then ie toggles reach irq one clock later.
        run_txn(2'd1, 1'b0, 4, '1, -1, 1'b1);
        ie = 1'b0; @(negedge clk);
        chk("irq_ie_off", irq, 0);
        ie = 1'b1; @(negedge clk);
        chk("irq_ie_on", irq, 1);

        for (int r = 0; r < 20; r++) begin
            cqv = {$urandom(), $urandom(), $urandom(), $urandom()};
            run_txn(AW'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, TS + TO + 3)), cqv,
                    ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 12)) : -1,
                    1'($urandom_range(0, 1)));
        end

        // Reset in the middle of S1.
        @(negedge clk);
        sel = 1'b1; cx1 = 1'b1;
        bound = 0;
        do begin
            @(negedge clk);
            bound++;
        end while (!c1 && bound < 20);
        chk("reach_s1", c1, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_c1", c1, 0);
        chk("rst_mid_rdy", rdy, 1);
        chk("rst_mid_sel2", sel2, 0);
        reset = 1'b0; sel = 1'b0; cx1 = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_rst_idle", {rdy, c1, c2, sel2}, 4'b1000);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
